acumulador_sumas: RTL and testbench

- Stage directly downstream of the pipelined 4-bit adder (sumador).
- Consumes the adder's delayed sum/index stream and accumulates each 4-bit sum into one of 16 per-index accumulators, addressed by the accompanying 4-bit index.
- Provides a registered read port with optional clear-on-read, per-entry sticky overflow and a dropped-sample counter.
- An init sweep FSM clears storage after reset or flush.

---
 rtl/acumulador_sumas_if.sv | 31 +++
 rtl/acumulador_sumas.sv | 123 ++++++++++++
 tb/tb_acumulador_sumas.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acumulador_sumas_if.sv
// Sample/read bundle between the upstream driver (adder side plus reader) and acumulador_sumas.
interface acumulador_sumas_if #(
    parameter int DATA_W = 4,
    parameter int IDX_W  = 4,
    parameter int ACC_W  = 8
);
    logic              valid_in;
    logic [DATA_W-1:0] sum_in;
    logic [IDX_W-1:0]  idx_in;
    logic              flush;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_clr;
    logic              ready;
    logic              rd_valid;
    logic [ACC_W-1:0]  rd_data;
    logic              rd_ovf;
    logic [IDX_W-1:0]  rd_idx_out;
    logic              ovf_any;
    logic [7:0]        drop_cnt;

    modport master (
        output valid_in, sum_in, idx_in, flush, rd_req, rd_idx, rd_clr,
        input  ready, rd_valid, rd_data, rd_ovf, rd_idx_out, ovf_any, drop_cnt
    );

    modport slave (
        input  valid_in, sum_in, idx_in, flush, rd_req, rd_idx, rd_clr,
        output ready, rd_valid, rd_data, rd_ovf, rd_idx_out, ovf_any, drop_cnt
    );
endinterface

// File: rtl/acumulador_sumas.sv
// Per-index accumulator bank behind the pipelined adder, with registered read port and init sweep.
// Define ACUM_SATURATE_EN to saturate entries at full scale instead of wrapping.
module acumulador_sumas #(
    parameter int DATA_W = 4,
    parameter int IDX_W  = 4,
    parameter int ACC_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    acumulador_sumas_if.slave  bus
);
    localparam int NUM = 2**IDX_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_ready;
    logic              r_rd_valid;
    logic [ACC_W-1:0]  r_rd_data;
    logic              r_rd_ovf;
    logic [IDX_W-1:0]  r_rd_idx_out;
    logic              r_ovf_any;
    logic [7:0]        r_drop_cnt;
    logic [NUM-1:0]    r_ovf;
    logic [ACC_W-1:0]  r_mem [NUM];

    logic              w_run;
    logic              w_clr;
    logic              w_acc;
    logic              w_clr_hit;
    logic [ACC_W-1:0]  w_base;
    logic              w_ovf_base;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  w_new;

    function automatic logic [ACC_W-1:0] f_fit(input logic [ACC_W:0] s);
`ifdef ACUM_SATURATE_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    assign w_run      = (r_state == S_RUN) && !reset && !bus.flush;
    assign w_clr      = w_run && bus.rd_req && bus.rd_clr;
    assign w_acc      = w_run && bus.valid_in;
    // A clearing read of the same entry zeroes the base so this cycle's sample survives the clear.
    assign w_clr_hit  = w_clr && (bus.rd_idx == bus.idx_in);
    assign w_base     = w_clr_hit ? '0 : r_mem[bus.idx_in];
    assign w_ovf_base = w_clr_hit ? 1'b0 : r_ovf[bus.idx_in];
    assign w_sum      = {1'b0, w_base} + {{(ACC_W+1-DATA_W){1'b0}}, bus.sum_in};
    assign w_new      = f_fit(w_sum);

    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && r_state == S_INIT)
            r_mem[r_cnt] <= '0;
        if (w_clr)
            r_mem[bus.rd_idx] <= '0;
        if (w_acc)
            r_mem[bus.idx_in] <= w_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_ovf     <= 1'b0;
            r_rd_idx_out <= '0;
            r_ovf_any    <= 1'b0;
            r_drop_cnt   <= '0;
            r_ovf        <= '0;
        end else if (bus.flush) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_ovf_any  <= 1'b0;
            r_drop_cnt <= '0;
            r_ovf      <= '0;
        end else begin
            r_ovf_any  <= |r_ovf;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_ovf[r_cnt] <= 1'b0;
                    r_cnt        <= r_cnt + IDX_W'(1);
                    if (bus.valid_in && r_drop_cnt != 8'hFF)
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    if (&r_cnt) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Read captures the pre-update contents of this cycle.
                    if (bus.rd_req) begin
                        r_rd_valid   <= 1'b1;
                        r_rd_data    <= r_mem[bus.rd_idx];
                        r_rd_ovf     <= r_ovf[bus.rd_idx];
                        r_rd_idx_out <= bus.rd_idx;
                    end
                    if (w_clr)
                        r_ovf[bus.rd_idx] <= 1'b0;
                    if (w_acc)
                        r_ovf[bus.idx_in] <= w_ovf_base | w_sum[ACC_W];
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.ready      = r_ready;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_ovf     = r_rd_ovf;
    assign bus.rd_idx_out = r_rd_idx_out;
    assign bus.ovf_any    = r_ovf_any;
    assign bus.drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_acumulador_sumas.sv
// Bench for acumulador_sumas: behavioural accumulator model plus directed and random traffic.
module tb_acumulador_sumas;
    localparam int DATA_W = 4;
    localparam int IDX_W  = 4;
    localparam int ACC_W  = 8;
`ifdef ACUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    acumulador_sumas_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ACC_W(ACC_W)) bus ();

    acumulador_sumas #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: plain integer storage, phase tracked as remaining init cycles.
    int m_mem [16];
    bit m_ovf [16];
    int init_left = 16;
    bit e_ready, e_rd_valid, e_rd_ovf, e_ovf_any;
    int e_rd_data, e_rd_idx, e_drop;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit any;
        int t;
        any = 1'b0;
        foreach (m_ovf[i]) any |= m_ovf[i];
        if (reset) begin
            init_left = 16;
            e_ready = 0; e_rd_valid = 0; e_rd_data = 0; e_rd_ovf = 0;
            e_rd_idx = 0; e_ovf_any = 0; e_drop = 0;
            foreach (m_ovf[i]) m_ovf[i] = 0;
        end else if (bus.flush) begin
            init_left = 16;
            e_ready = 0; e_rd_valid = 0; e_drop = 0; e_ovf_any = 0;
            foreach (m_ovf[i]) m_ovf[i] = 0;
        end else begin
            e_ovf_any  = any;
            e_rd_valid = 0;
            if (init_left > 0) begin
                if (bus.valid_in && e_drop < 255) e_drop++;
                m_mem[16 - init_left] = 0;
                m_ovf[16 - init_left] = 0;
                init_left--;
                if (init_left == 0) e_ready = 1;
            end else begin
                if (bus.rd_req) begin
                    e_rd_valid = 1;
                    e_rd_data  = m_mem[bus.rd_idx];
                    e_rd_ovf   = m_ovf[bus.rd_idx];
                    e_rd_idx   = int'(bus.rd_idx);
                    if (bus.rd_clr) begin
                        m_mem[bus.rd_idx] = 0;
                        m_ovf[bus.rd_idx] = 0;
                    end
                end
                if (bus.valid_in) begin
                    t = m_mem[bus.idx_in] + int'(bus.sum_in);
                    if (t > 255) begin
                        m_ovf[bus.idx_in] = 1;
                        m_mem[bus.idx_in] = SAT ? 255 : t - 256;
                    end else begin
                        m_mem[bus.idx_in] = t;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready",    bus.ready,      e_ready);
            check("cyc_rd_valid", bus.rd_valid,   e_rd_valid);
            check("cyc_rd_data",  bus.rd_data,    e_rd_data);
            check("cyc_rd_ovf",   bus.rd_ovf,     e_rd_ovf);
            check("cyc_rd_idx",   bus.rd_idx_out, e_rd_idx);
            check("cyc_ovf_any",  bus.ovf_any,    e_ovf_any);
            check("cyc_drop",     bus.drop_cnt,   e_drop);
        end
    end

    task automatic send(input int idx, input int sum);
        bus.valid_in = 1'b1;
        bus.idx_in   = 4'(idx);
        bus.sum_in   = 4'(sum);
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic rd(input int idx, input bit clr);
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'(idx);
        bus.rd_clr = clr;
        @(negedge clk);
        bus.rd_req = 1'b0;
        bus.rd_clr = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.rd_req = 1'b1;
            bus.rd_idx = 4'(i);
            bus.rd_clr = 1'b0;
            @(negedge clk);
            check({tag, "_vld"},  bus.rd_valid,   1);
            check({tag, "_data"}, bus.rd_data,    0);
            check({tag, "_ovf"},  bus.rd_ovf,     0);
            check({tag, "_idx"},  bus.rd_idx_out, i);
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic count_init(input string tag);
        int low;
        low = 0;
        while (!bus.ready && low < 40) begin
            low++;
            @(negedge clk);
        end
        check({tag, "_low_cycles"}, low, 16);
    endtask

    initial begin
        int lowcnt;
        int d;
        int idx;
        reset = 1'b1;
        bus.valid_in = 0; bus.sum_in = 0; bus.idx_in = 0; bus.flush = 0;
        bus.rd_req = 0; bus.rd_idx = 0; bus.rd_clr = 0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;

        check("ready_init", bus.ready, 0);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("ready_init", bus.ready, 0);
        end
        @(negedge clk);
        check("ready_rise", bus.ready, 1);
        check("drop_after_reset", bus.drop_cnt, 0);
        read_all_zero("post_reset");

        send(3, 5); send(3, 7); send(9, 15);
        rd(3, 1'b0);
        check("sum3_vld", bus.rd_valid, 1);
        check("sum3_data", bus.rd_data, 12);
        check("sum3_idx", bus.rd_idx_out, 3);
        rd(9, 1'b0);
        check("sum9_data", bus.rd_data, 15);
        check("sum9_idx", bus.rd_idx_out, 9);
        @(negedge clk);
        check("rd_pulse_end", bus.rd_valid, 0);
        check("rd_hold_data", bus.rd_data, 15);

        repeat (18) send(2, 15);
        rd(2, 1'b0);
        check("ovf_data", bus.rd_data, SAT ? 255 : 14);
        check("ovf_flag", bus.rd_ovf, 1);
        check("ovf_any", bus.ovf_any, 1);

        send(4, 10);
        bus.valid_in = 1'b1; bus.idx_in = 4'd4; bus.sum_in = 4'd6;
        bus.rd_req = 1'b1; bus.rd_idx = 4'd4; bus.rd_clr = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0; bus.rd_req = 1'b0; bus.rd_clr = 1'b0;
        check("clr_old_data", bus.rd_data, 10);
        check("clr_old_ovf", bus.rd_ovf, 0);
        rd(4, 1'b0);
        check("clr_new_data", bus.rd_data, 6);
        check("clr_new_ovf", bus.rd_ovf, 0);

        for (int c = 0; c < 600; c++) begin
            idx = $urandom_range(0, 15);
            bus.valid_in = ($urandom_range(0, 3) != 0);
            bus.idx_in   = 4'(idx);
            bus.sum_in   = 4'($urandom_range(0, 15));
            bus.rd_req   = $urandom_range(0, 1);
            bus.rd_idx   = ($urandom_range(0, 1) != 0) ? 4'(idx) : 4'($urandom_range(0, 15));
            bus.rd_clr   = ($urandom_range(0, 3) == 0);
            bus.flush    = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.valid_in = 0; bus.rd_req = 0; bus.rd_clr = 0; bus.flush = 0;
        d = 0;
        while (!bus.ready && d < 40) begin
            @(negedge clk);
            d++;
        end
        check("ready_after_random", bus.ready, 1);

        bus.flush = 1'b1; bus.valid_in = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ovf_any", bus.ovf_any, 0);
        check("flush_ready", bus.ready, 0);
        lowcnt = 0;
        while (!bus.ready && lowcnt < 40) begin
            lowcnt++;
            bus.valid_in = (lowcnt <= 5);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        check("flush_low_cycles", lowcnt, 16);
        check("flush_drop", bus.drop_cnt, 5);
        read_all_zero("post_flush");

        repeat (18) send(1, 15);
        rd(1, 1'b0);
        check("pre_reset_ovf", bus.rd_ovf, 1);
        bus.rd_req = 1'b1; bus.rd_idx = 4'd1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.rd_req = 1'b0;
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_ovf", bus.rd_ovf, 0);
        check("rst_rd_idx", bus.rd_idx_out, 0);
        check("rst_ovf_any", bus.ovf_any, 0);
        check("rst_drop", bus.drop_cnt, 0);
        check("rst_ready", bus.ready, 0);
        count_init("rst");
        read_all_zero("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
